// File: rtl/axis_vid_pkg.sv
// rtl/axis_vid_pkg.sv - shared state encoding and default video timing constants
package axis_vid_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        HBLANK   = 2'd2,
        VBLANK   = 2'd3
    } vid_state_t;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int DEF_H_BLANK    = 160;
    localparam int DEF_V_BLANK    = 45;

endpackage

// File: rtl/vid_timing_cnt.sv
// rtl/vid_timing_cnt.sv - x/y position counters and blanking-length counter
module vid_timing_cnt
    import axis_vid_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int V_BLANK    = DEF_V_BLANK
) (
    input  logic clk,
    input  logic rst,
    input  logic x_inc,
    input  logic x_clr,
    input  logic y_inc,
    input  logic y_clr,
    input  logic b_inc,
    input  logic b_clr,
    output logic x_last,
    output logic y_last,
    output logic hb_done,
    output logic vb_done
);

    localparam int VB_LEN = V_BLANK * (IMG_WIDTH + H_BLANK);
    localparam int XW     = $clog2(IMG_WIDTH + 1);
    localparam int YW     = $clog2(IMG_HEIGHT + 1);
    localparam int BW     = $clog2(VB_LEN + 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [BW-1:0] b;

    // Clear wins over increment so the controller can assert both freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            b <= '0;
        end else begin
            if (x_clr)      x <= '0;
            else if (x_inc) x <= x + 1'b1;
            if (y_clr)      y <= '0;
            else if (y_inc) y <= y + 1'b1;
            if (b_clr)      b <= '0;
            else if (b_inc) b <= b + 1'b1;
        end
    end

    assign x_last  = (x == XW'(IMG_WIDTH - 1));
    assign y_last  = (y == YW'(IMG_HEIGHT - 1));
    assign hb_done = (b == BW'(H_BLANK - 1));
    assign vb_done = (b == BW'(VB_LEN - 1));

endmodule

// File: rtl/axis_to_vid_out.sv
// rtl/axis_to_vid_out.sv - stream-to-video timing master; AXIS2VID_ERR_CNT_EN adds err_cnt
module axis_to_vid_out
    import axis_vid_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int V_BLANK    = DEF_V_BLANK
) (
    input  logic                  m_axis_aclk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_active,
    output logic                  vid_hblank,
    output logic                  vid_vblank,
    output logic                  vid_fsync,
    output logic                  err_underflow,
`ifdef AXIS2VID_ERR_CNT_EN
    output logic [15:0]           err_cnt,
`endif
    output logic                  err_sync
);

    vid_state_t            state, nxt;
    logic                  x_inc, x_clr, y_inc, y_clr, b_inc, b_clr;
    logic                  x_last, y_last, hb_done, vb_done;
    logic                  pix_vld, fsync_d, uf, se;
    logic [DATA_WIDTH-1:0] pix_data;

    vid_timing_cnt #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .H_BLANK   (H_BLANK),
        .V_BLANK   (V_BLANK)
    ) u_cnt (
        .clk    (m_axis_aclk),
        .rst    (rst),
        .x_inc  (x_inc),
        .x_clr  (x_clr),
        .y_inc  (y_inc),
        .y_clr  (y_clr),
        .b_inc  (b_inc),
        .b_clr  (b_clr),
        .x_last (x_last),
        .y_last (y_last),
        .hb_done(hb_done),
        .vb_done(vb_done)
    );

    assign s_axis_tready = !rst && (state == WAIT_SOF || state == ACTIVE);

    always_comb begin
        nxt      = state;
        x_inc    = 1'b0;
        x_clr    = 1'b0;
        y_inc    = 1'b0;
        y_clr    = 1'b0;
        b_inc    = 1'b0;
        b_clr    = 1'b0;
        pix_vld  = 1'b0;
        pix_data = '0;
        fsync_d  = 1'b0;
        uf       = 1'b0;
        se       = 1'b0;
        case (state)
            WAIT_SOF: begin
                y_clr = 1'b1;
                b_clr = 1'b1;
                x_clr = 1'b1;
                // The start-of-frame beat occupies slot x=0 of the first line.
                if (s_axis_tvalid && s_axis_tuser) begin
                    pix_vld  = 1'b1;
                    pix_data = s_axis_tdata;
                    fsync_d  = 1'b1;
                    se       = (s_axis_tlast != x_last);
                    if (x_last) begin
                        nxt = HBLANK;
                    end else begin
                        nxt   = ACTIVE;
                        x_clr = 1'b0;
                        x_inc = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    se    = 1'b1;
                    nxt   = WAIT_SOF;
                    x_clr = 1'b1;
                    y_clr = 1'b1;
                    b_clr = 1'b1;
                end else begin
                    pix_vld  = 1'b1;
                    pix_data = s_axis_tvalid ? s_axis_tdata : '0;
                    uf       = !s_axis_tvalid;
                    se       = s_axis_tvalid && (s_axis_tlast != x_last);
                    if (x_last) begin
                        nxt   = HBLANK;
                        x_clr = 1'b1;
                        b_clr = 1'b1;
                    end else begin
                        x_inc = 1'b1;
                    end
                end
            end
            HBLANK: begin
                if (hb_done) begin
                    b_clr = 1'b1;
                    if (y_last) begin
                        nxt = VBLANK;
                    end else begin
                        nxt   = ACTIVE;
                        y_inc = 1'b1;
                    end
                end else begin
                    b_inc = 1'b1;
                end
            end
            VBLANK: begin
                if (vb_done) begin
                    nxt   = WAIT_SOF;
                    b_clr = 1'b1;
                    y_clr = 1'b1;
                end else begin
                    b_inc = 1'b1;
                end
            end
            default: nxt = WAIT_SOF;
        endcase
    end

    // Blanking flags come from the current state so they line up with vid_data.
    always_ff @(posedge m_axis_aclk) begin
        if (rst) begin
            state         <= WAIT_SOF;
            vid_data      <= '0;
            vid_active    <= 1'b0;
            vid_hblank    <= 1'b0;
            vid_vblank    <= 1'b0;
            vid_fsync     <= 1'b0;
            err_underflow <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            state         <= nxt;
            vid_data      <= pix_data;
            vid_active    <= pix_vld;
            vid_hblank    <= (state == HBLANK);
            vid_vblank    <= (state == VBLANK);
            vid_fsync     <= fsync_d;
            err_underflow <= err_underflow | uf;
            err_sync      <= err_sync | se;
        end
    end

`ifdef AXIS2VID_ERR_CNT_EN
    always_ff @(posedge m_axis_aclk) begin
        if (rst)
            err_cnt <= '0;
        else if ((uf || se) && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axis_to_vid_out.sv
// tb/tb_axis_to_vid_out.sv - directed self-checking bench for axis_to_vid_out
module tb_axis_to_vid_out;

    logic       m_axis_aclk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic [9:0] vid_data;
    logic       vid_active, vid_hblank, vid_vblank, vid_fsync;
    logic       err_underflow, err_sync;
`ifdef AXIS2VID_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int   total = 0;
    int   bad = 0;
    logic tr;

    always #5 m_axis_aclk = ~m_axis_aclk;

    axis_to_vid_out #(
        .DATA_WIDTH(10),
        .IMG_WIDTH (8),
        .IMG_HEIGHT(4),
        .H_BLANK   (2),
        .V_BLANK   (1)
    ) dut (
        .m_axis_aclk  (m_axis_aclk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .vid_data     (vid_data),
        .vid_active   (vid_active),
        .vid_hblank   (vid_hblank),
        .vid_vblank   (vid_vblank),
        .vid_fsync    (vid_fsync),
        .err_underflow(err_underflow),
`ifdef AXIS2VID_ERR_CNT_EN
        .err_cnt      (err_cnt),
`endif
        .err_sync     (err_sync)
    );

    typedef struct {
        logic       v, u, l;
        logic [9:0] d;
        logic       tr, a;
        logic [9:0] od;
        logic       fs, hb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are read at the next falling edge.
    task automatic cyc(input logic v, input logic u, input logic l, input logic [9:0] d);
        s_axis_tvalid = v;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = d;
        #1 tr = s_axis_tready;
        @(negedge m_axis_aclk);
    endtask

    task automatic outs(input logic a, input logic [9:0] d, input logic fs, input logic hb, input logic vb);
        chk("vid_active", vid_active, a);
        chk("vid_data", vid_data, d);
        chk("vid_fsync", vid_fsync, fs);
        chk("vid_hblank", vid_hblank, hb);
        chk("vid_vblank", vid_vblank, vb);
    endtask

    task automatic flags(input logic uf, input logic se);
        chk("err_underflow", err_underflow, uf);
        chk("err_sync", err_sync, se);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b0, 10'h3FF);
        chk("rst_tready", tr, 0);
        outs(0, 10'h0, 0, 0, 0);
        flags(0, 0);
`ifdef AXIS2VID_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
    endtask

    // One 8-pixel line plus its two blanking cycles; data encodes {y,x}.
    task automatic line(input bit sof, input int y, input int inv_x, input int tl_x);
        for (int x = 0; x < 8; x++) begin
            cyc(x != inv_x, sof && x == 0, x == tl_x, 10'(y * 16 + x));
            chk("line_tready", tr, 1);
            outs(1, (x == inv_x) ? 10'h0 : 10'(y * 16 + x), sof && x == 0, 0, 0);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 10'h3FF);
            chk("hb_tready", tr, 0);
            outs(0, 10'h0, 0, 1, 0);
        end
    endtask

    initial begin
        vec_t tbl[14];
        tbl[0]  = '{1, 0, 0, 10'h3AA, 1, 0, 10'h000, 0, 0};
        tbl[1]  = '{1, 0, 0, 10'h155, 1, 0, 10'h000, 0, 0};
        tbl[2]  = '{0, 0, 0, 10'h000, 1, 0, 10'h000, 0, 0};
        tbl[3]  = '{1, 1, 0, 10'h100, 1, 1, 10'h100, 1, 0};
        tbl[4]  = '{1, 0, 0, 10'h101, 1, 1, 10'h101, 0, 0};
        tbl[5]  = '{1, 0, 0, 10'h102, 1, 1, 10'h102, 0, 0};
        tbl[6]  = '{1, 0, 0, 10'h103, 1, 1, 10'h103, 0, 0};
        tbl[7]  = '{1, 0, 0, 10'h104, 1, 1, 10'h104, 0, 0};
        tbl[8]  = '{1, 0, 0, 10'h105, 1, 1, 10'h105, 0, 0};
        tbl[9]  = '{1, 0, 0, 10'h106, 1, 1, 10'h106, 0, 0};
        tbl[10] = '{1, 0, 1, 10'h107, 1, 1, 10'h107, 0, 0};
        tbl[11] = '{1, 0, 0, 10'h2AA, 0, 0, 10'h000, 0, 1};
        tbl[12] = '{1, 0, 0, 10'h2AB, 0, 0, 10'h000, 0, 1};
        tbl[13] = '{1, 0, 0, 10'h110, 1, 1, 10'h110, 0, 0};

        @(negedge m_axis_aclk);
        do_reset();

        // Garbage drop, start of frame, first line and start of second line.
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v, tbl[i].u, tbl[i].l, tbl[i].d);
            chk("tbl_tready", tr, tbl[i].tr);
            outs(tbl[i].a, tbl[i].od, tbl[i].fs, tbl[i].hb, 0);
        end
        flags(0, 0);

        // Full frame with continuous ramp data.
        do_reset();
        line(1, 0, -1, 7);
        for (int y = 1; y < 4; y++) line(0, y, -1, 7);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 10'h3FF);
            chk("vb_tready", tr, 0);
            outs(0, 10'h0, 0, 0, 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 10'h0AA);
        chk("sof_wait_tready", tr, 1);
        outs(0, 10'h0, 0, 0, 0);
        flags(0, 0);

        // Underflow at x=3.
        do_reset();
        line(1, 0, 3, 7);
        flags(1, 0);
`ifdef AXIS2VID_ERR_CNT_EN
        chk("uf_err_cnt", err_cnt, 1);
`endif

        // Early tlast at x=5, so x=7 also lacks tlast.
        do_reset();
        line(1, 0, -1, 5);
        flags(0, 1);
`ifdef AXIS2VID_ERR_CNT_EN
        chk("tlast_err_cnt", err_cnt, 2);
`endif

        // tuser mid-line at (4,1).
        do_reset();
        line(1, 0, -1, 7);
        for (int x = 0; x < 4; x++) begin
            cyc(1'b1, 1'b0, 1'b0, 10'(16 + x));
            outs(1, 10'(16 + x), 0, 0, 0);
        end
        cyc(1'b1, 1'b1, 1'b0, 10'h03C);
        chk("tuser_mid_tready", tr, 1);
        outs(0, 10'h0, 0, 0, 0);
        flags(0, 1);
`ifdef AXIS2VID_ERR_CNT_EN
        chk("tuser_err_cnt", err_cnt, 1);
`endif
        cyc(1'b1, 1'b0, 1'b0, 10'h055);
        chk("resync_tready", tr, 1);
        outs(0, 10'h0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 10'h077);
        outs(1, 10'h077, 1, 0, 0);

        // Reset pulse mid-ACTIVE, then a fresh frame.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 10'h200);
        cyc(1'b0, 1'b0, 1'b0, 10'h000);
        flags(1, 0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 10'h202);
        chk("midrst_tready", tr, 0);
        outs(0, 10'h0, 0, 0, 0);
        flags(0, 0);
        rst = 1'b0;
        line(1, 0, -1, 7);
        flags(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
